// File: rtl/alu_issue_stage.sv
// Execute-issue stage: decodes opcode/funct into an ALU operation and operands, then registers them for the ALU.
// Latency: 1 cycle from accept to OUT_VALID when the stage is empty; sustains 1 entry/cycle while OUT_READY=1.
// Backpressure: a 2-entry skid buffer (main + skid) lets IN_READY come straight from a flop; IN_READY drops only when both entries are full.
module alu_issue_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPRN_WIDTH     = 6,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      FLUSH,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [5:0]                IN_OPCODE,
  input  logic [5:0]                IN_FUNCT,
  input  logic [4:0]                IN_SHAMT,
  input  logic [15:0]               IN_IMM,
  input  logic [DATA_WIDTH-1:0]     IN_RS_DATA,
  input  logic [DATA_WIDTH-1:0]     IN_RT_DATA,
  input  logic [REG_ADDR_WIDTH-1:0] IN_DST,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [DATA_WIDTH-1:0]     OUT_OP1,
  output logic [DATA_WIDTH-1:0]     OUT_OP2,
  output logic [OPRN_WIDTH-1:0]     OUT_OPRN,
  output logic [REG_ADDR_WIDTH-1:0] OUT_DST,
  output logic                      OUT_ILLEGAL
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state_q, state_d;
  logic   rdy_q, rdy_d;

  // main entry is what the ALU sees; skid entry holds the one accepted while main was stalled
  logic [DATA_WIDTH-1:0]     op1_q, op2_q, sk_op1_q, sk_op2_q;
  logic [OPRN_WIDTH-1:0]     oprn_q, sk_oprn_q;
  logic [REG_ADDR_WIDTH-1:0] dst_q, sk_dst_q;
  logic                      ill_q, sk_ill_q;

  logic [DATA_WIDTH-1:0] dec_op1, dec_op2, imm_se, imm_ze, shamt_ze;
  logic [OPRN_WIDTH-1:0] dec_oprn;
  logic                  dec_ill;
  logic                  accept, deliver;
  logic                  load_main, load_skid, skid_to_main;

  assign imm_se   = {{(DATA_WIDTH-16){IN_IMM[15]}}, IN_IMM};
  assign imm_ze   = {{(DATA_WIDTH-16){1'b0}}, IN_IMM};
  assign shamt_ze = {{(DATA_WIDTH-5){1'b0}}, IN_SHAMT};

  assign accept  = IN_VALID & rdy_q;
  assign deliver = (state_q != EMPTY) & OUT_READY;

  // Decode opcode/funct to ALU operation and select/extend operands; unknown encodings become a zeroed illegal entry
  always_comb begin
    dec_op1  = '0;
    dec_op2  = '0;
    dec_oprn = '0;
    dec_ill  = 1'b0;
    if (IN_OPCODE == 6'h00) begin
      dec_op1 = IN_RS_DATA;
      dec_op2 = IN_RT_DATA;
      case (IN_FUNCT)
        6'h20: dec_oprn = OPRN_WIDTH'(1);
        6'h22: dec_oprn = OPRN_WIDTH'(2);
        6'h2C: dec_oprn = OPRN_WIDTH'(3);
        6'h02: begin dec_oprn = OPRN_WIDTH'(4); dec_op1 = IN_RT_DATA; dec_op2 = shamt_ze; end
        6'h00: begin dec_oprn = OPRN_WIDTH'(5); dec_op1 = IN_RT_DATA; dec_op2 = shamt_ze; end
        6'h24: dec_oprn = OPRN_WIDTH'(6);
        6'h25: dec_oprn = OPRN_WIDTH'(7);
        6'h27: dec_oprn = OPRN_WIDTH'(8);
        6'h2A: dec_oprn = OPRN_WIDTH'(9);
        default: begin dec_ill = 1'b1; dec_op1 = '0; dec_op2 = '0; end
      endcase
    end else begin
      dec_op1 = IN_RS_DATA;
      case (IN_OPCODE)
        6'h08, 6'h23, 6'h2B: begin dec_oprn = OPRN_WIDTH'(1); dec_op2 = imm_se; end
        6'h1D:               begin dec_oprn = OPRN_WIDTH'(3); dec_op2 = imm_se; end
        6'h0C:               begin dec_oprn = OPRN_WIDTH'(6); dec_op2 = imm_ze; end
        6'h0D:               begin dec_oprn = OPRN_WIDTH'(7); dec_op2 = imm_ze; end
        6'h0A:               begin dec_oprn = OPRN_WIDTH'(9); dec_op2 = imm_se; end
        6'h04, 6'h05:        begin dec_oprn = OPRN_WIDTH'(2); dec_op2 = IN_RT_DATA; end
        default:             begin dec_ill = 1'b1; dec_op1 = '0; end
      endcase
    end
  end

  // Occupancy next-state and entry movement; flush overrides everything and drops any same-cycle input
  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (!FLUSH) begin
      case (state_q)
        EMPTY: if (accept) begin state_d = ONE; load_main = 1'b1; end
        ONE: begin
          if (accept && !deliver) begin state_d = TWO; load_skid = 1'b1; end
          else if (accept && deliver) begin load_main = 1'b1; end
          else if (deliver) begin state_d = EMPTY; end
        end
        TWO: if (deliver) begin state_d = ONE; skid_to_main = 1'b1; end
        default: state_d = EMPTY;
      endcase
    end else begin
      state_d = EMPTY;
    end
    rdy_d = (state_d != TWO);
  end

  // State and registered ready; ready stays low during reset so inputs are ignored until the first edge after release
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
    end
  end

  // Entry registers; data holds on flush, only the illegal flags are cleared
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op1_q <= '0; op2_q <= '0; oprn_q <= '0; dst_q <= '0; ill_q <= 1'b0;
      sk_op1_q <= '0; sk_op2_q <= '0; sk_oprn_q <= '0; sk_dst_q <= '0; sk_ill_q <= 1'b0;
    end else if (FLUSH) begin
      ill_q    <= 1'b0;
      sk_ill_q <= 1'b0;
    end else begin
      if (load_main) begin
        op1_q <= dec_op1; op2_q <= dec_op2; oprn_q <= dec_oprn; dst_q <= IN_DST; ill_q <= dec_ill;
      end else if (skid_to_main) begin
        op1_q <= sk_op1_q; op2_q <= sk_op2_q; oprn_q <= sk_oprn_q; dst_q <= sk_dst_q; ill_q <= sk_ill_q;
      end
      if (load_skid) begin
        sk_op1_q <= dec_op1; sk_op2_q <= dec_op2; sk_oprn_q <= dec_oprn; sk_dst_q <= IN_DST; sk_ill_q <= dec_ill;
      end
    end
  end

  assign IN_READY    = rdy_q;
  assign OUT_VALID   = (state_q != EMPTY);
  assign OUT_OP1     = op1_q;
  assign OUT_OP2     = op2_q;
  assign OUT_OPRN    = oprn_q;
  assign OUT_DST     = dst_q;
  assign OUT_ILLEGAL = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized traffic against a queue model.
module tb_alu_issue_stage;
  logic        CLK = 1'b0;
  logic        RST, FLUSH, IN_VALID, IN_READY, OUT_VALID, OUT_READY, OUT_ILLEGAL;
  logic [5:0]  IN_OPCODE, IN_FUNCT, OUT_OPRN;
  logic [4:0]  IN_SHAMT, IN_DST, OUT_DST;
  logic [15:0] IN_IMM;
  logic [31:0] IN_RS_DATA, IN_RT_DATA, OUT_OP1, OUT_OP2;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [5:0]  oprn;
    logic [4:0]  dst;
    logic        ill;
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int failures = 0;

  // R-type funct table in ALU-code order (index+1 = OPRN); I-type opcode list
  logic [5:0] rfn [9]  = '{6'h20, 6'h22, 6'h2C, 6'h02, 6'h00, 6'h24, 6'h25, 6'h27, 6'h2A};
  logic [5:0] iop [10] = '{6'h08, 6'h23, 6'h2B, 6'h1D, 6'h0C, 6'h0D, 6'h0A, 6'h04, 6'h05, 6'h3F};

  alu_issue_stage #(.DATA_WIDTH(32), .OPRN_WIDTH(6), .REG_ADDR_WIDTH(5)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_OPCODE(IN_OPCODE), .IN_FUNCT(IN_FUNCT), .IN_SHAMT(IN_SHAMT), .IN_IMM(IN_IMM),
    .IN_RS_DATA(IN_RS_DATA), .IN_RT_DATA(IN_RT_DATA), .IN_DST(IN_DST),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_OP1(OUT_OP1), .OUT_OP2(OUT_OP2),
    .OUT_OPRN(OUT_OPRN), .OUT_DST(OUT_DST), .OUT_ILLEGAL(OUT_ILLEGAL)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Reference decode from the instruction table
  function automatic ent_t ref_dec(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                                   input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [4:0] dst);
    ent_t e;
    logic [31:0] se, ze;
    se = 32'($signed(imm));
    ze = {16'h0, imm};
    e = '{op1: 32'h0, op2: 32'h0, oprn: 6'h0, dst: dst, ill: 1'b1};
    if (opc == 6'h00) begin
      for (int i = 0; i < 9; i++) begin
        if (fn == rfn[i]) begin
          e.oprn = 6'(i + 1);
          e.ill  = 1'b0;
          e.op1  = (i == 3 || i == 4) ? rt : rs;
          e.op2  = (i == 3 || i == 4) ? {27'h0, sh} : rt;
        end
      end
    end else begin
      e.ill = 1'b0;
      e.op1 = rs;
      case (opc)
        6'h08, 6'h23, 6'h2B: begin e.oprn = 6'd1; e.op2 = se; end
        6'h1D:               begin e.oprn = 6'd3; e.op2 = se; end
        6'h0C:               begin e.oprn = 6'd6; e.op2 = ze; end
        6'h0D:               begin e.oprn = 6'd7; e.op2 = ze; end
        6'h0A:               begin e.oprn = 6'd9; e.op2 = se; end
        6'h04, 6'h05:        begin e.oprn = 6'd2; e.op2 = rt; end
        default:             begin e.ill = 1'b1; e.op1 = 32'h0; end
      endcase
    end
    return e;
  endfunction

  task automatic set_op(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] dst);
    IN_VALID = 1'b1; IN_OPCODE = opc; IN_FUNCT = fn; IN_SHAMT = sh; IN_IMM = imm;
    IN_RS_DATA = rs; IN_RT_DATA = rt; IN_DST = dst;
  endtask

  // legal_only=1 picks from the supported table; otherwise an arbitrary opcode/funct can appear
  task automatic rand_op(input bit legal_only);
    int k;
    k = legal_only ? $urandom_range(0, 17) : $urandom_range(0, 20);
    if (k < 9)
      set_op(6'h00, rfn[k], 5'($urandom), 16'($urandom), $urandom, $urandom, 5'($urandom));
    else if (k < 19)
      set_op(iop[k-9], 6'($urandom), 5'($urandom), 16'($urandom), $urandom, $urandom, 5'($urandom));
    else
      set_op(6'($urandom), 6'($urandom), 5'($urandom), 16'($urandom), $urandom, $urandom, 5'($urandom));
  endtask

  // One clock: drive OUT_READY/FLUSH, advance the queue model, return at the next falling edge
  task automatic step(input logic ordy, input logic fl);
    bit acc, dlv;
    ent_t e;
    OUT_READY = ordy;
    FLUSH = fl;
    acc = IN_VALID && (q.size() < 2);
    dlv = (q.size() > 0) && ordy;
    e = ref_dec(IN_OPCODE, IN_FUNCT, IN_SHAMT, IN_IMM, IN_RS_DATA, IN_RT_DATA, IN_DST);
    @(posedge CLK);
    if (fl) q.delete();
    else begin
      if (dlv) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(negedge CLK);
    FLUSH = 1'b0;
    if (fl || acc) IN_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    set_op(6'h0, 6'h0, 5'h0, 16'h0, 32'h0, 32'h0, 5'h0);
    IN_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", OUT_VALID); end
    checks++; if ({OUT_OP1, OUT_OP2, OUT_OPRN, OUT_DST} !== 75'h0) begin failures++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", OUT_OP1, OUT_OP2, OUT_OPRN, OUT_DST); end
    checks++; if (OUT_ILLEGAL !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", OUT_ILLEGAL); end
    RST = 1'b0;
    q.delete();
    step(1'b0, 1'b0);
    checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", IN_READY); end
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid_after got=%b exp=0", OUT_VALID); end
  endtask

  task automatic test_add();
    set_op(6'h00, 6'h20, 5'h0, 16'h0, 32'd5, 32'd7, 5'd3);
    step(1'b1, 1'b0);
    checks++; if (OUT_VALID !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", OUT_VALID); end
    checks++; if ({OUT_OPRN, OUT_OP1, OUT_OP2, OUT_ILLEGAL, OUT_DST} !== {6'd1, 32'd5, 32'd7, 1'b0, 5'd3})
      begin failures++; $display("FAIL add_fields got=%h/%h/%h/%b/%h exp=1/5/7/0/3", OUT_OPRN, OUT_OP1, OUT_OP2, OUT_ILLEGAL, OUT_DST); end
    step(1'b1, 1'b0);
  endtask

  task automatic test_extension();
    set_op(6'h08, 6'h0, 5'h0, 16'hFFFC, 32'h10, 32'h0, 5'd1);
    step(1'b1, 1'b0);
    checks++; if ({OUT_OPRN, OUT_OP1, OUT_OP2} !== {6'd1, 32'h10, 32'hFFFFFFFC})
      begin failures++; $display("FAIL addi_se got=%h/%h/%h exp=1/10/fffffffc", OUT_OPRN, OUT_OP1, OUT_OP2); end
    set_op(6'h0D, 6'h0, 5'h0, 16'h8000, 32'h3, 32'h0, 5'd2);
    step(1'b1, 1'b0);
    checks++; if ({OUT_OPRN, OUT_OP2} !== {6'd7, 32'h00008000})
      begin failures++; $display("FAIL ori_ze got=%h/%h exp=7/00008000", OUT_OPRN, OUT_OP2); end
    set_op(6'h00, 6'h00, 5'd4, 16'h0, 32'h99, 32'd1, 5'd3);
    step(1'b1, 1'b0);
    checks++; if ({OUT_OPRN, OUT_OP1, OUT_OP2} !== {6'd5, 32'd1, 32'd4})
      begin failures++; $display("FAIL sll_shamt got=%h/%h/%h exp=5/1/4", OUT_OPRN, OUT_OP1, OUT_OP2); end
    step(1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    set_op(6'h00, 6'h20, 5'h0, 16'h0, 32'hA, 32'h1, 5'd1);
    step(1'b0, 1'b0);
    set_op(6'h00, 6'h22, 5'h0, 16'h0, 32'hB, 32'h2, 5'd2);
    step(1'b0, 1'b0);
    checks++; if (IN_READY !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%b exp=0", IN_READY); end
    set_op(6'h00, 6'h24, 5'h0, 16'h0, 32'hC, 32'h3, 5'd3);
    step(1'b0, 1'b0);
    checks++; if ({OUT_VALID, IN_READY, OUT_OP1, OUT_OPRN} !== {1'b1, 1'b0, 32'hA, 6'd1})
      begin failures++; $display("FAIL bp_hold_a got=%b/%b/%h/%h exp=1/0/a/1", OUT_VALID, IN_READY, OUT_OP1, OUT_OPRN); end
    step(1'b1, 1'b0);
    checks++; if ({OUT_VALID, IN_READY, OUT_OP1, OUT_OPRN} !== {1'b1, 1'b1, 32'hB, 6'd2})
      begin failures++; $display("FAIL bp_deliver_b got=%b/%b/%h/%h exp=1/1/b/2", OUT_VALID, IN_READY, OUT_OP1, OUT_OPRN); end
    step(1'b1, 1'b0);
    checks++; if ({OUT_VALID, OUT_OP1, OUT_OPRN} !== {1'b1, 32'hC, 6'd6})
      begin failures++; $display("FAIL bp_deliver_c got=%b/%h/%h exp=1/c/6", OUT_VALID, OUT_OP1, OUT_OPRN); end
    step(1'b1, 1'b0);
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", OUT_VALID); end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 8; i++) begin
      rand_op(1'b1);
      step(1'b1, 1'b0);
      checks++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b1 || q.size() != 1)
        begin failures++; $display("FAIL stream_flow[%0d] got=rdy%b vld%b exp=rdy1 vld1", i, IN_READY, OUT_VALID); end
      else begin
        checks++; if ({OUT_OP1, OUT_OP2, OUT_OPRN, OUT_DST, OUT_ILLEGAL} !== q[0])
          begin failures++; $display("FAIL stream_entry[%0d] got=%h exp=%h", i, {OUT_OP1, OUT_OP2, OUT_OPRN, OUT_DST, OUT_ILLEGAL}, q[0]); end
      end
    end
    step(1'b1, 1'b0);
  endtask

  task automatic test_illegal();
    set_op(6'h3F, 6'h20, 5'd7, 16'h1234, 32'h1234, 32'h5678, 5'd9);
    step(1'b1, 1'b0);
    checks++; if ({OUT_VALID, OUT_ILLEGAL, OUT_OPRN, OUT_OP1, OUT_OP2, OUT_DST} !== {1'b1, 1'b1, 6'd0, 32'd0, 32'd0, 5'd9})
      begin failures++; $display("FAIL illegal got=%b/%b/%h/%h/%h/%h exp=1/1/0/0/0/9", OUT_VALID, OUT_ILLEGAL, OUT_OPRN, OUT_OP1, OUT_OP2, OUT_DST); end
    step(1'b1, 1'b0);
  endtask

  task automatic test_flush();
    set_op(6'h3F, 6'h0, 5'h0, 16'h0, 32'h1, 32'h2, 5'd1);
    step(1'b0, 1'b0);
    set_op(6'h00, 6'h20, 5'h0, 16'h0, 32'h3, 32'h4, 5'd2);
    step(1'b0, 1'b0);
    set_op(6'h00, 6'h22, 5'h0, 16'h0, 32'h5, 32'h6, 5'd3);
    step(1'b0, 1'b1);
    checks++; if ({OUT_VALID, IN_READY, OUT_ILLEGAL} !== 3'b010)
      begin failures++; $display("FAIL flush got=vld%b rdy%b ill%b exp=vld0 rdy1 ill0", OUT_VALID, IN_READY, OUT_ILLEGAL); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL flush_nodeliver[%0d] got=%b exp=0", i, OUT_VALID); end
    end
  endtask

  task automatic test_rst_mid();
    set_op(6'h00, 6'h25, 5'h0, 16'h0, 32'h77, 32'h88, 5'd4);
    step(1'b0, 1'b0);
    checks++; if (OUT_VALID !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%b exp=1", OUT_VALID); end
    #2 RST = 1'b1;
    #1;
    checks++; if ({OUT_VALID, OUT_OPRN} !== {1'b0, 6'd0})
      begin failures++; $display("FAIL rstmid_async got=vld%b oprn%h exp=vld0 oprn0", OUT_VALID, OUT_OPRN); end
    @(negedge CLK);
    RST = 1'b0;
    q.delete();
    step(1'b0, 1'b0);
    checks++; if ({OUT_VALID, IN_READY} !== 2'b01)
      begin failures++; $display("FAIL rstmid_recover got=vld%b rdy%b exp=vld0 rdy1", OUT_VALID, IN_READY); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if (!IN_VALID && $urandom_range(0, 3) != 0) rand_op(1'b0);
      checks++; if (OUT_VALID !== (q.size() > 0))
        begin failures++; $display("FAIL rand_valid[%0d] got=%b exp=%b", c, OUT_VALID, q.size() > 0); end
      checks++; if (IN_READY !== (q.size() < 2))
        begin failures++; $display("FAIL rand_ready[%0d] got=%b exp=%b", c, IN_READY, q.size() < 2); end
      if (q.size() > 0) begin
        checks++; if ({OUT_OP1, OUT_OP2, OUT_OPRN, OUT_DST, OUT_ILLEGAL} !== q[0])
          begin failures++; $display("FAIL rand_entry[%0d] got=%h exp=%h", c, {OUT_OP1, OUT_OP2, OUT_OPRN, OUT_DST, OUT_ILLEGAL}, q[0]); end
      end
      step($urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_extension();
    test_backpressure();
    test_streaming();
    test_illegal();
    test_flush();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
